// File: rtl/andsinina_pkg.sv
// Shared helpers for the SININA masked/replicated AND gadget: share-pair
// indexing, bit packing and the pipeline latency.
package andsinina_pkg;

  localparam int LATENCY = 3;

  function automatic int rand_w(input int shares);
    return shares * (shares - 1) / 2;
  endfunction

  // Row-major enumeration of pairs i<j: (0,1),(0,2),..,(1,2),..
  function automatic int pair_idx(input int i, input int j, input int shares);
    return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int bit_idx(input int s, input int k, input int copies);
    return s * copies + k;
  endfunction

endpackage

// File: rtl/and_sinina_param_vote.sv
// N-way majority voter with a disagreement flag, one per partial-product term.
module sinina_maj_vote #(
  parameter int N = 3
) (
  input  logic [N-1:0] in_i,
  output logic         maj_o,
  output logic         mis_o
);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int k = 0; k < N; k++) ones = ones + CW'(in_i[k]);
  end

  assign maj_o = (ones > CW'(N / 2));
  assign mis_o = (|in_i) & ~(&in_i);

endmodule

// File: rtl/and_sinina_param.sv
// Pipelined SHARES-share / COPIES-replica SININA AND: multiply, majority-correct,
// compress. Optional saturating fault counter under ANDSININA_FAULT_CNT_EN.
module and_sinina_param
  import andsinina_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int COPIES = 3,
  parameter int FCNT_W = 8,
  localparam int RAND_W = rand_w(SHARES),
  localparam int W      = SHARES * COPIES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [W-1:0]      port_a,
  input  logic [W-1:0]      port_b,
  input  logic [RAND_W-1:0] port_r,
  output logic              out_valid,
  output logic [W-1:0]      port_c,
  output logic              fault_o
`ifdef ANDSININA_FAULT_CNT_EN
  ,
  output logic [FCNT_W-1:0] fault_cnt
`endif
);
  localparam int NT = SHARES * SHARES;

  if (SHARES < 2 || COPIES < 3 || (COPIES % 2) == 0 || FCNT_W < 1) begin : g_bad_cfg
    $fatal(1, "and_sinina_param: need SHARES>=2, odd COPIES>=3, FCNT_W>=1");
  end

  logic [LATENCY:1]           vld_pipe_q;
  logic [NT-1:0][COPIES-1:0]  u_d, u_q;
  logic [NT-1:0][COPIES-1:0]  v_d, v_q;
  logic [NT-1:0]              maj, mis;
  logic                       mis_q;
  logic [W-1:0]               c_d, c_q;
  logic                       fault_q;

  // Term t = i*SHARES+j holds all copies of u_i_j; the same r bit feeds
  // every copy so replicas stay comparable.
  for (genvar i = 0; i < SHARES; i++) begin : g_i
    for (genvar j = 0; j < SHARES; j++) begin : g_j
      localparam int T = i * SHARES + j;
      logic [COPIES-1:0] a_c, b_c;
      for (genvar k = 0; k < COPIES; k++) begin : g_k
        assign a_c[k] = port_a[bit_idx(i, k, COPIES)];
        assign b_c[k] = port_b[bit_idx(j, k, COPIES)];
      end
      if (i == j) begin : g_diag
        assign u_d[T] = a_c & b_c;
      end else if (i < j) begin : g_up
        assign u_d[T] = (a_c & b_c) ^ {COPIES{port_r[pair_idx(i, j, SHARES)]}};
      end else begin : g_lo
        assign u_d[T] = (a_c & b_c) ^ {COPIES{port_r[pair_idx(j, i, SHARES)]}};
      end

      sinina_maj_vote #(.N(COPIES)) u_vote (
        .in_i  (u_q[T]),
        .maj_o (maj[T]),
        .mis_o (mis[T])
      );
      assign v_d[T] = {COPIES{maj[T]}};
    end
  end

  for (genvar i = 0; i < SHARES; i++) begin : g_c
    for (genvar k = 0; k < COPIES; k++) begin : g_ck
      logic [SHARES-1:0] row;
      for (genvar j = 0; j < SHARES; j++) begin : g_cj
        assign row[j] = v_q[i * SHARES + j][k];
      end
      assign c_d[bit_idx(i, k, COPIES)] = ^row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      u_q        <= '0;
      v_q        <= '0;
      mis_q      <= 1'b0;
      c_q        <= '0;
      fault_q    <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[LATENCY-1:1], in_valid};
      u_q        <= u_d;
      v_q        <= v_d;
      mis_q      <= |mis;
      c_q        <= c_d;
      fault_q    <= mis_q & vld_pipe_q[2];
    end
  end

  assign out_valid = vld_pipe_q[LATENCY];
  assign port_c    = c_q;
  assign fault_o   = fault_q;

`ifdef ANDSININA_FAULT_CNT_EN
  logic [FCNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && fault_q && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign fault_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_and_sinina_param.sv
// Directed self-checking bench for and_sinina_param: defaults (2x3) and a 3x5
// instance; fault counter checks compile in with ANDSININA_FAULT_CNT_EN.
module tb_and_sinina_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       v_s;
  logic [5:0] a_s, b_s, c_s;
  logic [0:0] r_s;
  logic       ov_s, f_s;

  logic        v_b;
  logic [14:0] a_b, b_b, c_b;
  logic [2:0]  r_b;
  logic        ov_b, f_b;

`ifdef ANDSININA_FAULT_CNT_EN
  logic [7:0] cnt_s;
  logic [1:0] cnt_b;
`endif

  and_sinina_param #(.SHARES(2), .COPIES(3), .FCNT_W(8)) dut_s (
    .clk(clk), .reset(reset), .in_valid(v_s),
    .port_a(a_s), .port_b(b_s), .port_r(r_s),
    .out_valid(ov_s), .port_c(c_s), .fault_o(f_s)
`ifdef ANDSININA_FAULT_CNT_EN
    , .fault_cnt(cnt_s)
`endif
  );

  and_sinina_param #(.SHARES(3), .COPIES(5), .FCNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(v_b),
    .port_a(a_b), .port_b(b_b), .port_r(r_b),
    .out_valid(ov_b), .port_c(c_b), .fault_o(f_b)
`ifdef ANDSININA_FAULT_CNT_EN
    , .fault_cnt(cnt_b)
`endif
  );

  int ntest = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_s(input logic v, input logic [5:0] a, input logic [5:0] b, input logic r);
    v_s = v; a_s = a; b_s = b; r_s = r;
  endtask

  task automatic drv_b(input logic v, input logic [14:0] a, input logic [14:0] b, input logic [2:0] r);
    v_b = v; a_b = a; b_b = b; r_b = r;
  endtask

  // Big instance: a=1 (a0 only, copies 0,1 corrupted), b=1 (b2 only), r=101.
  localparam logic [14:0] BA = 15'b00000_00000_11100;
  localparam logic [14:0] BB = 15'b11111_00000_00000;
  localparam logic [14:0] BC = 15'b11111_00000_00000;

  initial begin
    logic [5:0] xa, xb;
    logic       ea, eb, ea0, eb0, er;
    logic [2:0] cx;
    logic [2:0] ab_q [32];

    drv_s(1'b0, '0, '0, 1'b0);
    drv_b(1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_ov_s", ov_s, 0);
    chk("rst_c_s", c_s, 0);
    chk("rst_f_s", f_s, 0);
    chk("rst_ov_b", ov_b, 0);
    chk("rst_c_b", c_b, 0);
`ifdef ANDSININA_FAULT_CNT_EN
    chk("rst_cnt_s", cnt_s, 0);
    chk("rst_cnt_b", cnt_b, 0);
`endif
    reset = 1'b0;

    // Unmasked 1&1: c0=0, c1=1
    @(negedge clk); drv_s(1'b1, 6'b000_111, 6'b111_000, 1'b1);
    @(negedge clk); drv_s(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("one_ov", ov_s, 1);
    chk("one_c", c_s, 6'b111_000);
    chk("one_f", f_s, 0);
    @(negedge clk);
    chk("one_ov_drop", ov_s, 0);

    // Single-copy fault on a0 copy 0
    drv_s(1'b1, 6'b000_110, 6'b111_000, 1'b1);
    @(negedge clk); drv_s(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("flt_ov", ov_s, 1);
    chk("flt_c", c_s, 6'b111_000);
    chk("flt_f", f_s, 1);
    repeat (3) @(negedge clk);
    chk("flt_f_clear", f_s, 0);

    // Exhaustive: n = {b,a,b0,a0,r}, back-to-back
    for (int n = 0; n < 36; n++) begin
      if (n >= 3) begin
        if (n - 3 < 32) begin
          cx = c_s[2:0] ^ c_s[5:3];
          chk($sformatf("exh_ov_%0d", n - 3), ov_s, 1);
          chk($sformatf("exh_xor_%0d", n - 3), cx, ab_q[n - 3]);
          chk($sformatf("exh_f_%0d", n - 3), f_s, 0);
        end else begin
          chk("exh_ov_tail", ov_s, 0);
        end
      end else begin
        chk($sformatf("exh_ov_pre_%0d", n), ov_s, 0);
      end
      if (n < 32) begin
        er = n[0]; ea0 = n[1]; eb0 = n[2]; ea = n[3]; eb = n[4];
        xa = {{3{ea ^ ea0}}, {3{ea0}}};
        xb = {{3{eb ^ eb0}}, {3{eb0}}};
        ab_q[n] = {3{ea & eb}};
        drv_s(1'b1, xa, xb, er);
      end else begin
        drv_s(1'b0, '0, '0, 1'b0);
      end
      @(negedge clk);
    end

    // Reset mid-flight drops both in-flight operations
    drv_s(1'b1, 6'b000_111, 6'b111_000, 1'b1);
    @(negedge clk); drv_s(1'b1, 6'b000_110, 6'b111_000, 1'b1);
    @(negedge clk); drv_s(1'b0, '0, '0, 1'b0); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("mid_ov_%0d", n), ov_s, 0);
      chk($sformatf("mid_c_%0d", n), c_s, 0);
      chk($sformatf("mid_f_%0d", n), f_s, 0);
      @(negedge clk);
    end

    // 3x5: two faulty copies of u_0_2 are outvoted
    drv_b(1'b1, BA, BB, 3'b101);
    @(negedge clk); drv_b(1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("big_ov", ov_b, 1);
    chk("big_c", c_b, BC);
    chk("big_f", f_b, 1);
    @(negedge clk);
    chk("big_ov_drop", ov_b, 0);

`ifdef ANDSININA_FAULT_CNT_EN
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("cnt_cleared", cnt_b, 0);
    for (int n = 0; n < 5; n++) begin
      drv_b(1'b1, BA, BB, 3'b101);
      @(negedge clk);
    end
    drv_b(1'b0, '0, '0, '0);
    repeat (6) @(negedge clk);
    chk("cnt_sat", cnt_b, 3);
    chk("cnt_s_zero", cnt_s, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
